// File: rtl/lfsr_pkg.sv
// Shared definitions for the 4-bit LFSR pattern generator and checker:
// state encoding, mode field positions and the LFSR step/lockup helpers.
package lfsr_pkg;

    typedef enum logic [1:0] {
        StHunt   = 2'd0,
        StVerify = 2'd1,
        StLocked = 2'd2
    } lfsr_state_e;

    // mode[0]: tap on s[0] instead of s[2]; mode[1]: XNOR feedback; mode[2]: stream inverted
    localparam int unsigned ModeTapBit  = 0;
    localparam int unsigned ModeXnorBit = 1;
    localparam int unsigned ModeInvBit  = 2;

    function automatic logic [3:0] lfsr4_next(input logic [3:0] s, input logic [2:0] mode);
        logic tap;
        logic fb;
        tap = mode[ModeTapBit] ? s[0] : s[2];
        fb  = s[3] ^ tap ^ mode[ModeXnorBit];
        return {s[2:0], fb};
    endfunction

    // The all-zero (XOR) or all-one (XNOR) word maps onto itself and cannot seed.
    function automatic logic lfsr4_is_lockup(input logic [3:0] s, input logic [2:0] mode);
        return mode[ModeXnorBit] ? (s == 4'hF) : (s == 4'h0);
    endfunction

endpackage

// File: rtl/lfsr4_popcnt.sv
// 4-bit to 3-bit combinational population count, used for bit-error counting.
module lfsr4_popcnt (
    input  logic [3:0] din,
    output logic [2:0] cnt
);

    assign cnt = 3'(din[0]) + 3'(din[1]) + 3'(din[2]) + 3'(din[3]);

endmodule

// File: rtl/lfsr4_checker.sv
// Receive-side checker for the 4-bit LFSR pattern generator. Self-synchronises a
// local LFSR to the incoming word stream, reports lock and counts errors.
// Optional build macro LFSR_CHK_BERT_EN: err_cnt accumulates bit errors
// (popcount of the mismatch) instead of mismatching words.
module lfsr4_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 3,
    parameter int unsigned ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [3:0]       in_data,
    input  logic [2:0]       mode,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       state
);

    localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);
    localparam int unsigned MissW  = $clog2(LOSS_CNT + 1);
    localparam logic [MatchW-1:0] LockCnt = MatchW'(LOCK_CNT);
    localparam logic [MissW-1:0]  LossCnt = MissW'(LOSS_CNT);
    localparam logic [ERR_W+2:0]  ErrMax  = {3'b000, {ERR_W{1'b1}}};

    lfsr_state_e       state_q, state_d;
    logic [3:0]        pred_q, pred_d;
    logic [MatchW-1:0] match_q, match_d;
    logic [MissW-1:0]  miss_q, miss_d;
    logic [2:0]        mode_q;
    logic              locked_q;
    logic              err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

    logic [3:0]        w;
    logic              w_lockup;
    logic [3:0]        w_next;
    logic [3:0]        pred_next;
    logic [MatchW-1:0] match_inc;
    logic [MissW-1:0]  miss_inc;
    logic              word_err;
    logic [2:0]        err_inc;
    logic [ERR_W+2:0]  err_sum;

    assign w         = in_data ^ {4{mode[ModeInvBit]}};
    assign w_lockup  = lfsr4_is_lockup(w, mode);
    assign w_next    = lfsr4_next(w, mode);
    assign pred_next = lfsr4_next(pred_q, mode);
    assign match_inc = match_q + MatchW'(1);
    assign miss_inc  = miss_q + MissW'(1);

`ifdef LFSR_CHK_BERT_EN
    logic [3:0] diff;
    assign diff = w ^ pred_q;
    lfsr4_popcnt u_popcnt (
        .din (diff),
        .cnt (err_inc)
    );
`else
    assign err_inc = 3'd1;
`endif

    // Next-state: hunt/verify/locked sequencing, prediction and run-length counters
    always_comb begin
        state_d     = state_q;
        pred_d      = pred_q;
        match_d     = match_q;
        miss_d      = miss_q;
        err_pulse_d = 1'b0;
        word_err    = 1'b0;
        if (mode != mode_q) begin
            // The word arriving with a mode change is discarded.
            state_d = StHunt;
            match_d = '0;
            miss_d  = '0;
        end else if (in_valid) begin
            case (state_q)
                StHunt: begin
                    if (!w_lockup) begin
                        pred_d  = w_next;
                        match_d = MatchW'(1);
                        state_d = StVerify;
                    end
                end
                StVerify: begin
                    if (w == pred_q) begin
                        pred_d  = w_next;
                        match_d = match_inc;
                        if (match_inc == LockCnt) begin
                            state_d = StLocked;
                            miss_d  = '0;
                        end
                    end else if (w_lockup) begin
                        state_d = StHunt;
                        match_d = '0;
                    end else begin
                        // Reseed from the received word without losing a cycle.
                        pred_d  = w_next;
                        match_d = MatchW'(1);
                    end
                end
                StLocked: begin
                    // Flywheel: prediction advances independently of received data.
                    pred_d = pred_next;
                    if (w == pred_q) begin
                        miss_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        word_err    = 1'b1;
                        if (miss_inc == LossCnt) begin
                            state_d = StHunt;
                            miss_d  = '0;
                            match_d = '0;
                        end else begin
                            miss_d = miss_inc;
                        end
                    end
                end
                default: begin
                    state_d = StHunt;
                    match_d = '0;
                    miss_d  = '0;
                end
            endcase
        end
    end

    // Saturating error counter; clear has priority over a same-cycle increment
    always_comb begin
        err_sum   = (ERR_W + 3)'(err_cnt_q) + (ERR_W + 3)'(err_inc);
        err_cnt_d = err_cnt_q;
        if (clr_cnt) begin
            err_cnt_d = '0;
        end else if (word_err) begin
            err_cnt_d = (err_sum > ErrMax) ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StHunt;
            pred_q      <= '0;
            match_q     <= '0;
            miss_q      <= '0;
            mode_q      <= mode;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            pred_q      <= pred_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            mode_q      <= mode;
            locked_q    <= (state_d == StLocked);
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_lfsr4_checker.sv
// Scoreboard bench for lfsr4_checker: a driver issues directed then random words
// and pushes the reference model's expected outputs; a monitor pops and compares.
// Two instances share the stimulus: ERR_W=8 and ERR_W=2 (saturation).
module tb_lfsr4_checker;

    typedef struct {
        int locked;
        int pulse;
        int cnt8;
        int cnt2;
        int st;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic [2:0] mode = 3'd0;
    logic       clr_cnt = 1'b0;

    logic       locked_a, pulse_a, locked_b, pulse_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic [1:0] state_a, state_b;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference model state (0 HUNT, 1 VERIFY, 2 LOCKED)
    int m_st, m_pred, m_match, m_miss, m_cnt8, m_cnt2, m_mode_prev, m_pulse;
    // Pattern generator feeding the link
    int gen;

    always #5 clk = ~clk;

    lfsr4_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(8)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .mode      (mode),
        .clr_cnt   (clr_cnt),
        .locked    (locked_a),
        .err_pulse (pulse_a),
        .err_cnt   (cnt_a),
        .state     (state_a)
    );

    lfsr4_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(2)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .mode      (mode),
        .clr_cnt   (clr_cnt),
        .locked    (locked_b),
        .err_pulse (pulse_b),
        .err_cnt   (cnt_b),
        .state     (state_b)
    );

    function automatic int nx(int s, int m);
        int fb;
        fb = ((s >> 3) & 1) ^ (((m & 1) != 0) ? (s & 1) : ((s >> 2) & 1)) ^ ((m >> 1) & 1);
        return ((s << 1) & 15) | fb;
    endfunction

    function automatic bit is_lockup(int s, int m);
        return s == ((((m >> 1) & 1) != 0) ? 15 : 0);
    endfunction

    function automatic int sat_add(int c, int inc, int maxv);
        return (c + inc > maxv) ? maxv : c + inc;
    endfunction

    task automatic model_step(bit r, bit v, int d, int m, bit c);
        int w, old, inc;
        bit err;
        err = 0;
        inc = 0;
        m_pulse = 0;
        if (r) begin
            m_st = 0; m_pred = 0; m_match = 0; m_miss = 0; m_cnt8 = 0; m_cnt2 = 0;
            m_mode_prev = m;
            return;
        end
        if (m != m_mode_prev) begin
            m_st = 0; m_match = 0; m_miss = 0;
        end else if (v) begin
            w = d ^ (((m & 4) != 0) ? 15 : 0);
            if (m_st == 0) begin
                if (!is_lockup(w, m)) begin
                    m_pred = nx(w, m); m_match = 1; m_st = 1;
                end
            end else if (m_st == 1) begin
                if (w == m_pred) begin
                    m_match++;
                    m_pred = nx(w, m);
                    if (m_match >= 4) begin m_st = 2; m_miss = 0; end
                end else if (is_lockup(w, m)) begin
                    m_st = 0; m_match = 0;
                end else begin
                    m_pred = nx(w, m); m_match = 1;
                end
            end else begin
                old = m_pred;
                m_pred = nx(m_pred, m);
                if (w == old) begin
                    m_miss = 0;
                end else begin
                    err = 1;
                    m_pulse = 1;
`ifdef LFSR_CHK_BERT_EN
                    inc = $countones(w ^ old);
`else
                    inc = 1;
`endif
                    m_miss++;
                    if (m_miss >= 3) begin m_st = 0; m_miss = 0; m_match = 0; end
                end
            end
        end
        m_mode_prev = m;
        if (c) begin
            m_cnt8 = 0; m_cnt2 = 0;
        end else if (err) begin
            m_cnt8 = sat_add(m_cnt8, inc, 255);
            m_cnt2 = sat_add(m_cnt2, inc, 3);
        end
    endtask

    task automatic drive(bit r, bit v, int d, int m, bit c);
        exp_t e;
        @(negedge clk);
        #1;
        reset = r; in_valid = v; in_data = d[3:0]; mode = m[2:0]; clr_cnt = c;
        model_step(r, v, d, m, c);
        e.locked = (m_st == 2) ? 1 : 0;
        e.pulse  = m_pulse;
        e.cnt8   = m_cnt8;
        e.cnt2   = m_cnt2;
        e.st     = m_st;
        exp_q.push_back(e);
    endtask

    // Generator emits its current word (inverted as mode requests) and advances.
    task automatic send_true(int m, bit c);
        drive(0, 1, gen ^ (((m & 4) != 0) ? 15 : 0), m, c);
        gen = nx(gen, m);
    endtask

    task automatic send_bad(int m, int mask, bit c);
        drive(0, 1, (gen ^ mask) ^ (((m & 4) != 0) ? 15 : 0), m, c);
        gen = nx(gen, m);
    endtask

    task automatic chk(string nm, logic [31:0] act, int expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, expv);
        end
    endtask

    // Monitor: outputs are valid every cycle; compare against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("state_a", 32'(state_a), e.st);
                chk("locked_a", 32'(locked_a), e.locked);
                chk("err_pulse_a", 32'(pulse_a), e.pulse);
                chk("err_cnt_a", 32'(cnt_a), e.cnt8);
                chk("state_b", 32'(state_b), e.st);
                chk("locked_b", 32'(locked_b), e.locked);
                chk("err_pulse_b", 32'(pulse_b), e.pulse);
                chk("err_cnt_b", 32'(cnt_b), e.cnt2);
            end
        end
    end

    initial begin
        int m, r;
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);

        // Acquire with mode 0: 1,2,4,9
        m = 0;
        gen = 1;
        repeat (4) send_true(m, 0);
        send_true(m, 0);                 // 3
        send_true(m, 0);                 // 6
        send_bad(m, 4'h8, 0);            // 5 in place of D
        send_true(m, 0);                 // back on track
        drive(0, 0, 0, m, 0);            // idle cycle holds everything
        repeat (3) send_bad(m, 4'h3, 0); // loss of lock
        drive(0, 1, 0, m, 0);            // lockup word stays in HUNT
        drive(0, 1, 0, 4, 0);            // mode change, word ignored
        m = 4;
        gen = 1;
        repeat (4) send_true(m, 0);      // E,D,B,6 on the wire
        // Scattered errors saturate the 2-bit counter without losing lock
        repeat (5) begin
            send_bad(m, 4'h1, 0);
            send_true(m, 0);
        end
        send_bad(m, 4'h2, 1);            // clear wins over increment
        send_true(m, 0);
        send_bad(m, 4'hF, 0);            // all four bits wrong
        send_true(m, 0);

        // Randomised link traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                drive(1, $urandom_range(0, 1), $urandom_range(0, 15), m, 0);
                gen = $urandom_range(1, 14);
            end else if (r < 5) begin
                m = $urandom_range(0, 7);
                drive(0, 1, $urandom_range(0, 15), m, 0);
                gen = $urandom_range(1, 14);
            end else if (r < 15) begin
                drive(0, 0, $urandom_range(0, 15), m, ($urandom_range(0, 19) == 0));
            end else if (r < 22) begin
                send_bad(m, $urandom_range(1, 15), ($urandom_range(0, 19) == 0));
            end else if (r < 24) begin
                drive(0, 1, $urandom_range(0, 15), m, 0);
            end else begin
                send_true(m, ($urandom_range(0, 49) == 0));
            end
        end

        @(negedge clk);
        @(negedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
